serial_frame_rx: RTL and testbench
==================================

SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 4, payload width in bits (minimum 2).
REQ-002 SHALL have parameter PARITY_EN, default 1, where 1 = even-parity bit present and 0 = no parity bit.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port bit_en  input  1  bit strobe; bit_in is sampled only on edges where bit_en=1.
REQ-006 SHALL have port bit_in  input  1  serial line; idle=1.
REQ-007 SHALL have port word_out  output  DATA_BITS  last received payload.
REQ-008 SHALL have port word_valid  output  1  one-cycle pulse when a frame completes with a good stop bit.
REQ-009 SHALL have port parity_err  output  1  one-cycle pulse, coincident with word_valid, when parity mismatches.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit is 0.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port err_count  output  8  saturating count of errored frames.

Function
REQ-013 SHALL use the frame format: start bit (0), then DATA_BITS payload bits LSB-first, then a parity bit if PARITY_EN=1, then a stop bit (1).
REQ-014 SHALL use the FSM states IDLE, DATA, PARITY, STOP; all transitions occur only on edges with bit_en=1.
REQ-015 SHALL, in IDLE with bit_en=1 and bit_in=0, go to DATA and clear the bit counter; bit_in=1 SHALL keep it in IDLE.
REQ-016 SHALL, in DATA, shift bit_in into the MSB of the shift register (shifting right) on each strobe; after DATA_BITS strobes it SHALL go to PARITY if PARITY_EN=1, else to STOP.
REQ-017 SHALL, in PARITY, capture the bit and go to STOP; the error condition is (XOR of payload) != parity bit.
REQ-018 SHALL, in STOP with bit_in=1, load word_out and pulse word_valid for exactly the one cycle following that edge, with parity_err=1 in the same cycle if the parity was wrong; the next state SHALL be IDLE.
REQ-019 SHALL, in STOP with bit_in=0, pulse frame_err for one cycle, keep word_valid=0, leave word_out unchanged, and go to IDLE.
REQ-020 SHALL hold word_out stable between word_valid pulses.
REQ-021 SHALL increment err_count by exactly 1 per frame with parity_err or frame_err (both in one frame = +1), saturating at 255.
REQ-022 SHALL ignore cycles with bit_en=0 entirely: no state, counter, or shift-register change.
REQ-023 SHALL accept a new start bit on the strobe immediately after the stop strobe (back-to-back frames).
REQ-024 SHALL size the bit counter to ceil(log2(DATA_BITS+1)) bits, with no wrap inside a frame.

Reset
REQ-025 SHALL, with reset=1 at a clk edge, force state=IDLE, word_out=0, word_valid=0, parity_err=0, frame_err=0, busy=0, err_count=0, and clear the shift register and bit counter.
REQ-026 SHALL have reset take priority over bit_en; a reset in the middle of a frame SHALL discard the partial frame with no pulses.

Structure
REQ-027 SHALL place the state enum typedef and the err_count width/saturation constants in a shared package (serial_pkg).
REQ-028 SHALL instantiate one sub-module, rx_shift_reg (DATA_BITS wide, right shift with serial-in at the MSB, enable input, sync clear), for payload assembly.

Verification (DATA_BITS=4, PARITY_EN=1, bit_en every 2nd cycle unless stated)
REQ-029 SHALL cover: start 0, data 1,1,0,1, parity 1, stop 1 -> word_out=4'hB, word_valid pulses exactly 1 cycle, parity_err=0, err_count=0.
REQ-030 SHALL cover: same frame with parity 0 -> word_out=4'hB, word_valid=1 and parity_err=1 in the same cycle, err_count=1.
REQ-031 SHALL cover: frame 4'h5 with stop 0 -> frame_err pulse, word_valid=0, word_out keeps its previous value, err_count+1.
REQ-032 SHALL cover: reset asserted after the 2nd data bit, then a clean frame 4'h3 -> no pulses from the aborted frame, word_out=4'h3, err_count=0.
REQ-033 SHALL cover: random bit_en gaps (0-5 cycles) plus back-to-back frames 4'hA,4'h6 -> two word_valid pulses in order; idle line 1 with no start -> busy stays 0.
REQ-034 SHALL cover: 260 frames with stop 0 -> err_count saturates at 255.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared types and constants for the serial frame receiver
//
// Contents:
//   rx_state_t   receiver FSM states (IDLE, DATA, PARITY, STOP)
//   ERR_CNT_W    width of the errored-frame counter
//   ERR_CNT_MAX  value at which the errored-frame counter sticks
//   err_cnt_inc  saturating increment for the errored-frame counter
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == ERR_CNT_MAX) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/serial_frame_rx_if.sv
// rtl/serial_frame_rx_if.sv - serial line and result bundle of the frame receiver
//
// Signals:
//   bit_en      bit strobe; bit_in only matters on strobed edges
//   bit_in      serial line, idles high
//   word_out    last good payload
//   word_valid  one-cycle pulse per frame with a good stop bit
//   parity_err  one-cycle pulse alongside word_valid on parity mismatch
//   frame_err   one-cycle pulse when the stop bit is low
//   busy        receiver is inside a frame
//   err_count   saturating count of errored frames
// Modports: master drives the line and watches results; slave is the receiver.
interface serial_frame_rx_if
  import serial_pkg::*;
#(
  parameter int DATA_BITS = 4
);
  logic                 bit_en;
  logic                 bit_in;
  logic [DATA_BITS-1:0] word_out;
  logic                 word_valid;
  logic                 parity_err;
  logic                 frame_err;
  logic                 busy;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output bit_en, bit_in,
    input  word_out, word_valid, parity_err, frame_err, busy, err_count
  );

  modport slave (
    input  bit_en, bit_in,
    output word_out, word_valid, parity_err, frame_err, busy, err_count
  );
endinterface

// File: rtl/rx_shift_reg.sv
// rtl/rx_shift_reg.sv - payload assembly shift register, serial-in at the MSB
//
// Ports:
//   clk    rising-edge clock
//   clear  synchronous clear, wins over en
//   en     shift one position right, loading sin into the MSB
//   sin    serial input bit
//   q      register contents; after WIDTH LSB-first shifts q holds the word
module rx_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= {sin, q[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// rtl/serial_frame_rx.sv - strobed serial frame receiver with parity and error count
//
// Frame: start(0), DATA_BITS payload bits LSB-first, optional even parity, stop(1).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; discards any partial frame silently
//   bus    serial_frame_rx_if slave modport (line in, results out)
// Parameters:
//   DATA_BITS  payload width (>= 2)
//   PARITY_EN  1 = even parity bit present, 0 = none
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int DATA_BITS = 4,
  parameter int PARITY_EN = 1
) (
  input  logic               clk,
  input  logic               reset,
  serial_frame_rx_if.slave   bus
);

  // Counter reaches DATA_BITS on the final data strobe, so it never wraps.
  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 par_bad;
  logic                 shift_en;

  logic [DATA_BITS-1:0] word_q;
  logic                 valid_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic [ERR_CNT_W-1:0] err_q;

  assign shift_en = bus.bit_en && (state == DATA);

  rx_shift_reg #(
    .WIDTH (DATA_BITS)
  ) u_shift (
    .clk   (clk),
    .clear (reset),
    .en    (shift_en),
    .sin   (bus.bit_in),
    .q     (shift_q)
  );

  // Even parity: payload XOR parity bit must be zero.
  generate
    if (PARITY_EN != 0) begin : g_par
      assign par_bad = (^shift_q) != par_q;
    end else begin : g_nopar
      assign par_bad = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.bit_en) begin
      unique case (state)
        IDLE:    if (!bus.bit_in) state_nxt = DATA;
        DATA:    if (bit_cnt == LAST_IDX) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= '0;
      par_q   <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      if (bus.bit_en) begin
        unique case (state)
          IDLE:   if (!bus.bit_in) bit_cnt <= '0;
          DATA:   bit_cnt <= bit_cnt + CNT_W'(1);
          PARITY: par_q <= bus.bit_in;
          STOP: begin
            if (bus.bit_in) begin
              word_q  <= shift_q;
              valid_q <= 1'b1;
              perr_q  <= par_bad;
            end else begin
              ferr_q  <= 1'b1;
            end
            // A frame with both a parity and a stop error counts once.
            if (!bus.bit_in || par_bad) err_q <= err_cnt_inc(err_q);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.err_count  = err_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb/tb_serial_frame_rx.sv - self-checking bench for serial_frame_rx
module tb_serial_frame_rx;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  serial_frame_rx_if #(.DATA_BITS(DB)) bus();

  serial_frame_rx #(.DATA_BITS(DB), .PARITY_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Monitor state, written only by the monitor process.
  logic [4:0] vq[$];
  int ferr_n   = 0;
  int stray_n  = 0;
  int busy_n   = 0;
  logic [3:0] prev_wo;
  bit in_reset = 1'b1;

  // Reader-side bookkeeping, written only by the main process.
  int vq_rd      = 0;
  int ferr_base  = 0;
  int stray_base = 0;
  int model_err  = 0;
  logic [3:0] model_word = 4'h0;

  typedef struct {
    logic [3:0] data;
    logic       par;
    logic       stop;
    int         exp_valid;
    logic [3:0] exp_word;
    logic       exp_perr;
    int         exp_ferr;
    int         exp_err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    forever begin
      @(negedge clk);
      if (bus.word_valid) vq.push_back({bus.parity_err, bus.word_out});
      if (bus.frame_err) ferr_n++;
      if (bus.parity_err && !bus.word_valid) stray_n++;
      if (bus.frame_err && bus.word_valid) stray_n++;
      if (!in_reset && !bus.word_valid && bus.word_out !== prev_wo) stray_n++;
      if (bus.busy) busy_n++;
      prev_wo = bus.word_out;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic b, input int gap);
    @(negedge clk);
    bus.bit_en = 1'b1;
    bus.bit_in = b;
    @(negedge clk);
    bus.bit_en = 1'b0;
    for (int i = 0; i < gap; i++) begin
      bus.bit_in = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.bit_in = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [3:0] data, input logic par, input logic stop,
                            input bit rnd, input int last_gap);
    strobe(1'b0, rnd ? $urandom_range(0, 5) : 0);
    for (int i = 0; i < DB; i++) strobe(data[i], rnd ? $urandom_range(0, 5) : 0);
    strobe(par, rnd ? $urandom_range(0, 5) : 0);
    strobe(stop, last_gap);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_frame(input string name, input logic [3:0] data, input logic par,
                              input logic stop, input int later);
    logic perr;
    int   pend;
    perr = (($countones(data) % 2) == 1) != par;
    if (stop) model_word = data;
    if ((!stop || perr) && model_err < 255) model_err++;
    pend = vq.size() - vq_rd;
    check({name, " valid count"}, pend, int'(stop) + later);
    if (stop && pend > 0) begin
      check({name, " word"}, vq[vq_rd][3:0], data);
      check({name, " parity_err"}, vq[vq_rd][4], perr);
      vq_rd++;
    end
    check({name, " frame_err"}, ferr_n - ferr_base, int'(!stop));
    ferr_base = ferr_n;
    check({name, " stray pulses"}, stray_n - stray_base, 0);
    stray_base = stray_n;
    if (later == 0) begin
      check({name, " err_count"}, bus.err_count, model_err);
      check({name, " word_out"}, bus.word_out, model_word);
    end
  endtask

  initial begin
    logic [3:0] d;
    logic       p, s;
    int         pend, busy_base;

    tbl[0] = '{4'hB, 1'b1, 1'b1, 1, 4'hB, 1'b0, 0, 0};
    tbl[1] = '{4'hB, 1'b0, 1'b1, 1, 4'hB, 1'b1, 0, 1};
    tbl[2] = '{4'h5, 1'b0, 1'b0, 0, 4'hB, 1'b0, 1, 2};
    tbl[3] = '{4'h0, 1'b0, 1'b1, 1, 4'h0, 1'b0, 0, 2};
    tbl[4] = '{4'hF, 1'b1, 1'b1, 1, 4'hF, 1'b1, 0, 3};
    tbl[5] = '{4'h7, 1'b0, 1'b0, 0, 4'hF, 1'b0, 1, 4};
    tbl[6] = '{4'h8, 1'b1, 1'b1, 1, 4'h8, 1'b0, 0, 4};

    reset      = 1'b1;
    bus.bit_en = 1'b0;
    bus.bit_in = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    settle();
    check("reset word_out", bus.word_out, 0);
    check("reset word_valid", bus.word_valid, 0);
    check("reset parity_err", bus.parity_err, 0);
    check("reset frame_err", bus.frame_err, 0);
    check("reset busy", bus.busy, 0);
    check("reset err_count", bus.err_count, 0);
    settle();
    in_reset   = 1'b0;
    ferr_base  = ferr_n;
    stray_base = stray_n;
    vq_rd      = vq.size();

    for (int k = 0; k < 7; k++) begin
      send_frame(tbl[k].data, tbl[k].par, tbl[k].stop, 1'b0, 0);
      settle();
      pend = vq.size() - vq_rd;
      check($sformatf("tbl%0d valid count", k), pend, tbl[k].exp_valid);
      if (pend > 0) begin
        check($sformatf("tbl%0d word", k), vq[vq_rd][3:0], tbl[k].exp_word);
        check($sformatf("tbl%0d parity_err", k), vq[vq_rd][4], tbl[k].exp_perr);
      end
      vq_rd = vq.size();
      check($sformatf("tbl%0d frame_err", k), ferr_n - ferr_base, tbl[k].exp_ferr);
      ferr_base = ferr_n;
      check($sformatf("tbl%0d stray", k), stray_n - stray_base, 0);
      stray_base = stray_n;
      check($sformatf("tbl%0d err_count", k), bus.err_count, tbl[k].exp_err);
      check($sformatf("tbl%0d word_out", k), bus.word_out, tbl[k].exp_word);
      model_err  = tbl[k].exp_err;
      model_word = tbl[k].exp_word;
    end

    // Reset in the middle of a frame, with bit_en high during the reset cycle.
    strobe(1'b0, 0);
    strobe(1'b1, 0);
    strobe(1'b1, 0);
    #1;
    check("mid-frame busy", bus.busy, 1);
    in_reset = 1'b1;
    @(negedge clk);
    reset      = 1'b1;
    bus.bit_en = 1'b1;
    bus.bit_in = 1'b0;
    @(negedge clk);
    reset      = 1'b0;
    bus.bit_en = 1'b0;
    bus.bit_in = 1'b1;
    settle();
    check("abort busy", bus.busy, 0);
    check("abort word_out", bus.word_out, 0);
    check("abort err_count", bus.err_count, 0);
    check("abort valid pulses", vq.size() - vq_rd, 0);
    check("abort frame_err", ferr_n - ferr_base, 0);
    settle();
    in_reset   = 1'b0;
    stray_base = stray_n;
    model_err  = 0;
    model_word = 4'h0;
    send_frame(4'h3, 1'b0, 1'b1, 1'b0, 0);
    settle();
    expect_frame("post-reset 3", 4'h3, 1'b0, 1'b1, 0);

    // Back-to-back frames with random gaps inside each frame.
    send_frame(4'hA, 1'b0, 1'b1, 1'b1, 0);
    send_frame(4'h6, 1'b0, 1'b1, 1'b1, 0);
    settle();
    expect_frame("b2b A", 4'hA, 1'b0, 1'b1, 1);
    expect_frame("b2b 6", 4'h6, 1'b0, 1'b1, 0);

    // Idle line: strobes with bit_in high never start a frame.
    busy_base = busy_n;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.bit_en = 1'b1;
      bus.bit_in = 1'b1;
      @(negedge clk);
      bus.bit_en = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    settle();
    check("idle busy cycles", busy_n - busy_base, 0);
    check("idle valid pulses", vq.size() - vq_rd, 0);

    for (int i = 0; i < 40; i++) begin
      d = 4'($urandom_range(0, 15));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s, 1'b1, $urandom_range(0, 5));
      settle();
      expect_frame($sformatf("rand%0d", i), d, p, s, 0);
    end

    for (int i = 0; i < 260; i++) begin
      d = 4'($urandom_range(0, 15));
      p = 1'($countones(d) % 2);
      send_frame(d, p, 1'b0, 1'b0, 0);
      settle();
      expect_frame($sformatf("sat%0d", i), d, p, 1'b0, 0);
    end
    check("saturated err_count", bus.err_count, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
